// File: rtl/axi4_stream_demux_buffered.sv
// axi4_stream_demux_buffered
//   1-to-2 AXI4-Stream packet demultiplexer with one FIFO per output.
//   The output is chosen by tdata[ROUTE_BIT] on the first beat of a packet
//   and held until tlast, so a packet is never split across outputs.
//
// Ports
//   s_axis_aclk_0      clock, all logic on the rising edge
//   s_axis_areset_0    synchronous reset, active-high
//   S_AXIS_*           input stream (tdata/tkeep/tuser/tlast/tvalid/tready)
//   M_AXIS_0_*         output stream 0 (route bit = 0)
//   M_AXIS_1_*         output stream 1 (route bit = 1)
//   occ_0 / occ_1      beats currently held in FIFO 0 / FIFO 1
//
// Route FSM
//   state     | meaning
//   ST_SOP    | next beat starts a packet; route taken from its tdata
//   ST_IN_PKT | inside a packet; route held in route_q until tlast
module axi4_stream_demux_buffered #(
    parameter int TDATA_L   = 512,
    parameter int TUSER_L   = 81,
    parameter int TKEEP_L   = 64,
    parameter int ROUTE_BIT = 28,
    parameter int DEPTH     = 8
) (
    input  logic                       s_axis_aclk_0,
    input  logic                       s_axis_areset_0,
    input  logic [TDATA_L-1:0]         S_AXIS_tdata,
    input  logic [TKEEP_L-1:0]         S_AXIS_tkeep,
    input  logic [TUSER_L-1:0]         S_AXIS_tuser,
    input  logic                       S_AXIS_tlast,
    input  logic                       S_AXIS_tvalid,
    output logic                       S_AXIS_tready,
    output logic [TDATA_L-1:0]         M_AXIS_0_tdata,
    output logic [TKEEP_L-1:0]         M_AXIS_0_tkeep,
    output logic [TUSER_L-1:0]         M_AXIS_0_tuser,
    output logic                       M_AXIS_0_tlast,
    output logic                       M_AXIS_0_tvalid,
    input  logic                       M_AXIS_0_tready,
    output logic [TDATA_L-1:0]         M_AXIS_1_tdata,
    output logic [TKEEP_L-1:0]         M_AXIS_1_tkeep,
    output logic [TUSER_L-1:0]         M_AXIS_1_tuser,
    output logic                       M_AXIS_1_tlast,
    output logic                       M_AXIS_1_tvalid,
    input  logic                       M_AXIS_1_tready,
    output logic [$clog2(DEPTH):0]     occ_0,
    output logic [$clog2(DEPTH):0]     occ_1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = TDATA_L + TKEEP_L + TUSER_L + 1;

    typedef enum logic {ST_SOP, ST_IN_PKT} state_t;

    state_t             state_q, state_d;
    logic               route_q, route_d;
    logic [PTR_W-1:0]   wr_ptr_q [2];
    logic [PTR_W-1:0]   wr_ptr_d [2];
    logic [PTR_W-1:0]   rd_ptr_q [2];
    logic [PTR_W-1:0]   rd_ptr_d [2];
    logic [OCC_W-1:0]   occ_q    [2];
    logic [OCC_W-1:0]   occ_d    [2];
    logic [ENT_W-1:0]   mem_q    [2][DEPTH];

    logic               route;
    logic               accept;
    logic [1:0]         full;
    logic [1:0]         empty;
    logic [1:0]         push;
    logic [1:0]         pop;
    logic [1:0]         m_valid;
    logic [1:0]         m_ready;
    logic [ENT_W-1:0]   s_entry;
    logic [ENT_W-1:0]   rd_entry_0;
    logic [ENT_W-1:0]   rd_entry_1;

    // On the first beat the route comes straight from tdata, so tready
    // depends on tdata combinationally while in ST_SOP.
    assign route = (state_q == ST_SOP) ? S_AXIS_tdata[ROUTE_BIT] : route_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]  = (occ_q[i] == OCC_W'(DEPTH));
            empty[i] = (occ_q[i] == '0);
        end
    end

    // No bypass: a full FIFO blocks input even if it pops this cycle.
    // Head-of-line blocking when the routed FIFO is full is intentional.
    assign S_AXIS_tready = !s_axis_areset_0 && !full[route];
    assign accept        = S_AXIS_tvalid && S_AXIS_tready;
    assign push          = {accept && route, accept && !route};

    assign m_ready = {M_AXIS_1_tready, M_AXIS_0_tready};
    assign m_valid = ~empty & {2{!s_axis_areset_0}};
    assign pop     = m_valid & m_ready;

    assign s_entry = {S_AXIS_tdata, S_AXIS_tkeep, S_AXIS_tuser, S_AXIS_tlast};

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (accept) begin
            if (S_AXIS_tlast) begin
                state_d = ST_SOP;
            end else if (state_q == ST_SOP) begin
                state_d = ST_IN_PKT;
                route_d = route;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            occ_d[i]    = occ_q[i];
            if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            if (push[i] && !pop[i])      occ_d[i] = occ_q[i] + OCC_W'(1);
            else if (pop[i] && !push[i]) occ_d[i] = occ_q[i] - OCC_W'(1);
        end
    end

    always_ff @(posedge s_axis_aclk_0) begin
        if (s_axis_areset_0) begin
            state_q <= ST_SOP;
            route_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                occ_q[i]    <= occ_d[i];
            end
        end
    end

    // Storage needs no reset; contents are only visible while occ is non-zero.
    always_ff @(posedge s_axis_aclk_0) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= s_entry;
        end
    end

    assign rd_entry_0 = mem_q[0][rd_ptr_q[0]];
    assign rd_entry_1 = mem_q[1][rd_ptr_q[1]];

    assign {M_AXIS_0_tdata, M_AXIS_0_tkeep, M_AXIS_0_tuser, M_AXIS_0_tlast} = rd_entry_0;
    assign {M_AXIS_1_tdata, M_AXIS_1_tkeep, M_AXIS_1_tuser, M_AXIS_1_tlast} = rd_entry_1;
    assign M_AXIS_0_tvalid = m_valid[0];
    assign M_AXIS_1_tvalid = m_valid[1];
    assign occ_0 = occ_q[0];
    assign occ_1 = occ_q[1];

endmodule
